mem_req_coalescer: RTL

// - Parametrised front end of the SIMT memory pipeline, between the operand collector and mem stage1.
// - Buffers up to DEPTH warp memory instructions behind a valid/ready handshake; the old single input register had no backpressure.
// - Computes per-lane effective addresses and splits each instruction into one request per distinct memory line touched.
// - Each per-line request carries a lane mask and per-lane word offsets.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_req_fifo.sv | 69 ++++++
 rtl/mem_req_coalescer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared defaults and helpers for the SIMT memory request coalescer.
// Holds the default geometry (lanes, word/address/line widths, FIFO depth,
// warp-ID width) and two width-agnostic helpers: line_of() extracts a line
// address from a word address, lowest_one() finds the lowest set bit of a mask.
package mem_pkg;

  localparam int DEF_LANES  = 8;
  localparam int DEF_WORD_W = 32;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_LINE_W = 3;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_WARP_W = 3;

  // Widest lane mask the helpers accept; callers zero-extend into this.
  localparam int MAX_LANES  = 32;

  // Line address of a word address: drop the word-in-line bits.
  function automatic logic [31:0] line_of(input logic [31:0] addr, input int line_w);
    return addr >> line_w;
  endfunction

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic int lowest_one(input logic [MAX_LANES-1:0] mask);
    int idx;
    idx = 0;
    for (int i = MAX_LANES - 1; i >= 0; i--) begin
      if (mask[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// mem_req_fifo: DEPTH-entry circular buffer of warp memory instructions.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// The active-lane mask is kept in its own array so the consumer can see both
// the head mask and the mask of the entry behind it (needed to start the next
// instruction immediately after the head retires).
// Ports:
//   clk, rst              clock, async active-low reset
//   push, wdata, wpam     write an entry (caller guarantees !full)
//   pop                   retire the head entry (caller guarantees !empty)
//   head_data, head_pam   head entry contents
//   next_pam              lane mask of the entry after the head
//   full, empty, count    occupancy status
module mem_req_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int PAM_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [PAM_W-1:0]         wpam,
  output logic [DATA_W-1:0]        head_data,
  output logic [PAM_W-1:0]         head_pam,
  output logic [PAM_W-1:0]         next_pam,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;
  localparam logic [PTR_W:0] DEPTH_C = DEPTH;

  logic [PTR_W:0]      wr_q;
  logic [PTR_W:0]      rd_q;
  logic [PTR_W:0]      rd_nxt;
  logic [DATA_W-1:0]   data_q [DEPTH];
  logic [PAM_W-1:0]    pam_q  [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PTR_ONE;
      if (pop)  rd_q <= rd_q + PTR_ONE;
    end
  end

  // Storage carries no reset: stale contents are never visible because
  // validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_q[PTR_W-1:0]] <= wdata;
      pam_q[wr_q[PTR_W-1:0]]  <= wpam;
    end
  end

  assign rd_nxt    = rd_q + PTR_ONE;
  assign count     = wr_q - rd_q;
  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign head_data = data_q[rd_q[PTR_W-1:0]];
  assign head_pam  = pam_q[rd_q[PTR_W-1:0]];
  assign next_pam  = pam_q[rd_nxt[PTR_W-1:0]];

endmodule

// File: rtl/mem_req_coalescer.sv
// mem_req_coalescer: front end of the SIMT memory pipeline.
// Accepts warp memory instructions behind a valid/ready handshake, computes
// per-lane effective addresses on entry, buffers them in a FIFO, and splits
// the head instruction into one request per distinct memory line, lowest
// active lane first. Each request carries a lane mask, per-lane word offsets
// and masked store data; out_last marks the final request of an instruction.
// Ports:
//   clk, rst                         clock, async active-low reset
//   in_valid/in_ready                instruction handshake (ready = !full)
//   in_read/in_write/in_shared       access kind
//   in_pam, in_warp, in_scb, in_reg  lane mask and bookkeeping fields
//   in_rs, in_rt, in_offset          per-lane base, store data, signed offset
//   out_valid/out_ready              per-line request handshake
//   out_*                            request contents
//   drop_err                         pulse: offered instruction was malformed
//   occupancy                        number of buffered instructions
module mem_req_coalescer
  import mem_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int WORD_W = DEF_WORD_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int WARP_W = DEF_WARP_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_read,
  input  logic                        in_write,
  input  logic                        in_shared,
  input  logic [LANES-1:0]            in_pam,
  input  logic [WARP_W-1:0]           in_warp,
  input  logic [1:0]                  in_scb,
  input  logic [4:0]                  in_reg,
  input  logic [LANES*WORD_W-1:0]     in_rs,
  input  logic [LANES*WORD_W-1:0]     in_rt,
  input  logic [15:0]                 in_offset,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_read,
  output logic                        out_write,
  output logic                        out_shared,
  output logic [WARP_W-1:0]           out_warp,
  output logic [1:0]                  out_scb,
  output logic [4:0]                  out_reg,
  output logic [ADDR_W-LINE_W-1:0]    out_line,
  output logic [LANES-1:0]            out_mask,
  output logic [LANES*LINE_W-1:0]     out_woff,
  output logic [LANES*WORD_W-1:0]     out_wdata,
  output logic                        out_last,
  output logic                        drop_err,
  output logic [$clog2(DEPTH):0]      occupancy
);

  localparam int LINEA_W = ADDR_W - LINE_W;
  localparam int LIDX_W  = $clog2(LANES);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int DATA_W  = 3 + WARP_W + 2 + 5 + LANES*ADDR_W + LANES*WORD_W;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SPLIT = 1'b1;

  // ---------------- push qualification ----------------
  logic accept;
  logic legal;
  logic push;
  logic drop_d;
  logic drop_q;

  assign accept = in_valid & in_ready;
  // Exactly one of load/store, and at least one active lane.
  assign legal  = (in_read != in_write) & (|in_pam);
  assign push   = accept & legal;
  assign drop_d = accept & ~legal;

  // ---------------- effective addresses ----------------
  logic signed [31:0]          off_ext;
  logic [ADDR_W-1:0]           off_addr;
  logic [LANES*ADDR_W-1:0]     eff_flat;
  logic [LANES-1:0]            rs_unused;
  logic                        unused_bits;

  assign off_ext  = 32'(signed'(in_offset));
  assign off_addr = off_ext[ADDR_W-1:0];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_eff
    // Address arithmetic wraps modulo 2^ADDR_W by construction.
    assign eff_flat[gi*ADDR_W +: ADDR_W] = in_rs[gi*WORD_W +: ADDR_W] + off_addr;
    assign rs_unused[gi] = ^in_rs[gi*WORD_W + ADDR_W +: WORD_W - ADDR_W];
  end

  assign unused_bits = ^{rs_unused, off_ext[31:ADDR_W]};

  // ---------------- instruction FIFO ----------------
  logic [DATA_W-1:0]  fifo_head;
  logic [LANES-1:0]   head_pam;
  logic [LANES-1:0]   next_pam;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               pop;

  mem_req_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .PAM_W  (LANES)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .wdata     ({in_read, in_write, in_shared, in_warp, in_scb, in_reg, eff_flat, in_rt}),
    .wpam      (in_pam),
    .head_data (fifo_head),
    .head_pam  (head_pam),
    .next_pam  (next_pam),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // No bypass: a pop in the same cycle does not free a slot for the push.
  assign in_ready  = ~fifo_full;
  assign occupancy = fifo_count;

  logic                        h_read;
  logic                        h_write;
  logic                        h_shared;
  logic [WARP_W-1:0]           h_warp;
  logic [1:0]                  h_scb;
  logic [4:0]                  h_reg;
  logic [LANES*ADDR_W-1:0]     h_eff;
  logic [LANES*WORD_W-1:0]     h_rt;

  assign {h_read, h_write, h_shared, h_warp, h_scb, h_reg, h_eff, h_rt} = fifo_head;

  // ---------------- line matching ----------------
  logic [0:0]          state_q;
  logic [0:0]          state_d;
  logic [LANES-1:0]    rem_q;
  logic [LANES-1:0]    rem_d;
  logic [LINEA_W-1:0]  h_line [LANES];
  logic [LIDX_W-1:0]   lead_idx;
  logic [LINEA_W-1:0]  lead_line;
  logic [LANES-1:0]    match;
  logic                last;
  logic                fire;

  assign lead_idx  = LIDX_W'(lowest_one(32'(rem_q)));
  assign lead_line = h_line[lead_idx];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign h_line[gi] = LINEA_W'(line_of(32'(h_eff[gi*ADDR_W +: ADDR_W]), LINE_W));
    assign match[gi]  = rem_q[gi] & (h_line[gi] == lead_line);
    assign out_woff[gi*LINE_W +: LINE_W]  = h_eff[gi*ADDR_W +: LINE_W];
    assign out_wdata[gi*WORD_W +: WORD_W] = match[gi] ? h_rt[gi*WORD_W +: WORD_W] : '0;
  end

  assign last = (match == rem_q);
  assign out_valid = (state_q == ST_SPLIT);
  assign fire = out_valid & out_ready;
  assign pop  = fire & last;

  // ---------------- split FSM ----------------
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_SPLIT;
          rem_d   = head_pam;
        end
      end
      ST_SPLIT: begin
        if (fire) begin
          if (last) begin
            // Chain straight into the next instruction if one remains after
            // the pop. With a single entry left, that next entry can only be
            // the one being pushed this very cycle.
            if (fifo_count > CNT_W'(1)) begin
              rem_d = next_pam;
            end else if (push) begin
              rem_d = in_pam;
            end else begin
              state_d = ST_IDLE;
              rem_d   = '0;
            end
          end else begin
            rem_d = rem_q & ~match;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        rem_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      drop_q  <= drop_d;
    end
  end

  // ---------------- outputs ----------------
  assign out_read   = h_read;
  assign out_write  = h_write;
  assign out_shared = h_shared;
  assign out_warp   = h_warp;
  assign out_scb    = h_scb;
  assign out_reg    = h_reg;
  assign out_line   = lead_line;
  assign out_mask   = match;
  assign out_last   = last;
  assign drop_err   = drop_q;

endmodule
